// File: rtl/vga_timing_out_if.sv
// Pixel-side and pin-side signals of the VGA timing/output stage.
// master = timing generator, slave = renderer / board pins.
interface vga_timing_out_if;
    logic [9:0] x;
    logic [9:0] y;
    logic       visible;
    logic       frame_tick;
    logic [7:0] r_in;
    logic [7:0] g_in;
    logic [7:0] b_in;
    logic       vga_hsync;
    logic       vga_vsync;
    logic       vga_blank_n;
    logic       vga_sync_n;
    logic [7:0] vga_r;
    logic [7:0] vga_g;
    logic [7:0] vga_b;

    modport master (
        output x, y, visible, frame_tick,
        output vga_hsync, vga_vsync, vga_blank_n, vga_sync_n,
        output vga_r, vga_g, vga_b,
        input  r_in, g_in, b_in
    );

    modport slave (
        input  x, y, visible, frame_tick,
        input  vga_hsync, vga_vsync, vga_blank_n, vga_sync_n,
        input  vga_r, vga_g, vga_b,
        output r_in, g_in, b_in
    );
endinterface

// File: rtl/vga_timing_out.sv
// VGA timing generator and registered DAC output stage: pixel coordinates,
// frame tick, and sync/blank/colour pins one clock behind the counters.
module vga_timing_out #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter bit HSYNC_POL = 1'b0,
    parameter bit VSYNC_POL = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    vga_timing_out_if.master vga
);
    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
    localparam logic [9:0] HS_FIRST = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HS_LAST  = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VS_LAST  = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);

    // Counters are 10 bits wide, so larger timings cannot be represented.
    generate
        if ((H_TOTAL > 1024) || (V_TOTAL > 1024)) begin : g_total_check
            $fatal(1, "vga_timing_out: H_TOTAL or V_TOTAL exceeds 1024");
        end
    endgenerate

    logic [9:0] hcount_r;
    logic [9:0] vcount_r;
    logic       hsync_r;
    logic       vsync_r;
    logic       blank_n_r;
    logic [7:0] red_r;
    logic [7:0] green_r;
    logic [7:0] blue_r;

    logic       h_wrap_s;
    logic       v_wrap_s;
    logic [9:0] h_next_s;
    logic [9:0] v_next_s;
    logic       visible_s;
    logic       frame_tick_s;
    logic       hsync_act_s;
    logic       vsync_act_s;
    logic [7:0] red_s;
    logic [7:0] green_s;
    logic [7:0] blue_s;

    // Next-count, region decode and blanked colour for the current position.
    always_comb begin
        h_wrap_s     = (hcount_r == H_LAST);
        v_wrap_s     = (vcount_r == V_LAST);
        h_next_s     = h_wrap_s ? 10'd0 : (hcount_r + 10'd1);
        v_next_s     = h_wrap_s ? (v_wrap_s ? 10'd0 : (vcount_r + 10'd1)) : vcount_r;
        visible_s    = (hcount_r < H_VIS) && (vcount_r < V_VIS);
        frame_tick_s = (hcount_r == 10'd0) && (vcount_r == V_VIS);
        hsync_act_s  = (hcount_r >= HS_FIRST) && (hcount_r <= HS_LAST);
        vsync_act_s  = (vcount_r >= VS_FIRST) && (vcount_r <= VS_LAST);
        red_s        = visible_s ? vga.r_in : 8'd0;
        green_s      = visible_s ? vga.g_in : 8'd0;
        blue_s       = visible_s ? vga.b_in : 8'd0;
    end

    // Horizontal/vertical position counters; both wrap together at frame end.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hcount_r <= 10'd0;
            vcount_r <= 10'd0;
        end else begin
            hcount_r <= h_next_s;
            vcount_r <= v_next_s;
        end
    end

    // Pin stage: everything the DAC sees is one clock behind the counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hsync_r   <= ~HSYNC_POL;
            vsync_r   <= ~VSYNC_POL;
            blank_n_r <= 1'b0;
            red_r     <= 8'd0;
            green_r   <= 8'd0;
            blue_r    <= 8'd0;
        end else begin
            hsync_r   <= hsync_act_s ? HSYNC_POL : ~HSYNC_POL;
            vsync_r   <= vsync_act_s ? VSYNC_POL : ~VSYNC_POL;
            blank_n_r <= visible_s;
            red_r     <= red_s;
            green_r   <= green_s;
            blue_r    <= blue_s;
        end
    end

    assign vga.x           = hcount_r;
    assign vga.y           = vcount_r;
    assign vga.visible     = visible_s;
    assign vga.frame_tick  = frame_tick_s;
    assign vga.vga_hsync   = hsync_r;
    assign vga.vga_vsync   = vsync_r;
    assign vga.vga_blank_n = blank_n_r;
    assign vga.vga_sync_n  = 1'b0;
    assign vga.vga_r       = red_r;
    assign vga.vga_g       = green_r;
    assign vga.vga_b       = blue_r;
endmodule

// File: tb/tb_vga_timing_out.sv
// Directed bench: a shrunken-timing instance for whole-frame behaviour and
// a default-timing instance for the standard 640x480 line timing.
module tb_vga_timing_out;
    localparam int HV = 16;
    localparam int HF = 2;
    localparam int HS = 3;
    localparam int HB = 3;
    localparam int HT = 24;
    localparam int VV = 10;
    localparam int VF = 2;
    localparam int VS = 2;
    localparam int VB = 3;
    localparam int VT = 17;
    localparam int FT = 408;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    logic ramp  = 1'b0;
    logic found = 1'b0;

    int checks    = 0;
    int errors    = 0;
    int cyc       = 0;
    int hs_run    = 0;
    int vs_run    = 0;
    int last_tick = -1;
    int ticks     = 0;
    int bhs_run   = 0;
    int bblank    = 0;
    int n         = 0;

    vga_timing_out_if bus ();
    vga_timing_out_if bbus ();

    vga_timing_out #(
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .HSYNC_POL(1'b0), .VSYNC_POL(1'b0)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .vga   (bus)
    );

    vga_timing_out u_big (
        .clk   (clk),
        .reset (reset),
        .vga   (bbus)
    );

    always #5 clk = ~clk;

    // Renderer models: constant white, or a coordinate ramp.
    always_comb begin
        if (ramp) begin
            bus.r_in = bus.x[7:0];
            bus.g_in = bus.y[7:0];
            bus.b_in = 8'h5A;
        end else begin
            bus.r_in = 8'hFF;
            bus.g_in = 8'hFF;
            bus.b_in = 8'hFF;
        end
    end

    assign bbus.r_in = 8'hFF;
    assign bbus.g_in = 8'hFF;
    assign bbus.b_in = 8'hFF;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s @cyc %0d: observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // p = clock edges since reset release (p >= 1)
    task automatic check_small(input int p);
        int cx, cy, qx, qy, qp;
        bit vis_c, vis_q;
        logic [31:0] er, eg, eb;
        cx = p % HT;
        cy = (p / HT) % VT;
        qp = (p - 1) % FT;
        qx = qp % HT;
        qy = qp / HT;
        vis_c = (cx < HV) && (cy < VV);
        vis_q = (qx < HV) && (qy < VV);
        chk("x", 32'(bus.x), 32'(cx));
        chk("y", 32'(bus.y), 32'(cy));
        chk("visible", 32'(bus.visible), 32'(vis_c));
        chk("frame_tick", 32'(bus.frame_tick), 32'((cx == 0) && (cy == VV)));
        chk("hsync", 32'(bus.vga_hsync), 32'(!((qx >= 18) && (qx <= 20))));
        chk("vsync", 32'(bus.vga_vsync), 32'(!((qy >= 12) && (qy <= 13))));
        chk("blank_n", 32'(bus.vga_blank_n), 32'(vis_q));
        chk("sync_n", 32'(bus.vga_sync_n), 32'd0);
        if (ramp) begin
            er = vis_q ? 32'(qx & 255) : 32'd0;
            eg = vis_q ? 32'(qy & 255) : 32'd0;
            eb = vis_q ? 32'h5A : 32'd0;
        end else begin
            er = vis_q ? 32'hFF : 32'd0;
            eg = er;
            eb = er;
        end
        chk("vga_r", 32'(bus.vga_r), er);
        chk("vga_g", 32'(bus.vga_g), eg);
        chk("vga_b", 32'(bus.vga_b), eb);
        if (bus.vga_hsync == 1'b0) begin
            if (hs_run == 0) chk("hsync_start_x", 32'(qx), 32'd18);
            hs_run++;
        end else if (hs_run != 0) begin
            chk("hsync_width", 32'(hs_run), 32'd3);
            hs_run = 0;
        end
        if (bus.vga_vsync == 1'b0) begin
            if (vs_run == 0) chk("vsync_start_pos", 32'(qp), 32'd288);
            vs_run++;
        end else if (vs_run != 0) begin
            chk("vsync_width", 32'(vs_run), 32'd48);
            vs_run = 0;
        end
        if (bus.frame_tick == 1'b1) begin
            if (last_tick >= 0) chk("tick_period", 32'(p - last_tick), 32'(FT));
            last_tick = p;
            ticks++;
        end
    endtask

    task automatic check_big(input int p);
        int q;
        q = (p - 1) % 800;
        chk("big_x", 32'(bbus.x), 32'(p % 800));
        chk("big_y", 32'(bbus.y), 32'(p / 800));
        chk("big_hsync", 32'(bbus.vga_hsync), 32'(!((q >= 656) && (q <= 751))));
        chk("big_vsync", 32'(bbus.vga_vsync), 32'd1);
        chk("big_blank_n", 32'(bbus.vga_blank_n), 32'(q < 640));
        chk("big_r", 32'(bbus.vga_r), (q < 640) ? 32'hFF : 32'd0);
        if (bbus.vga_hsync == 1'b0) begin
            if (bhs_run == 0) chk("big_hsync_start_x", 32'(q), 32'd656);
            bhs_run++;
        end else if (bhs_run != 0) begin
            chk("big_hsync_width", 32'(bhs_run), 32'd96);
            bhs_run = 0;
        end
        if (bbus.vga_blank_n == 1'b1) bblank++;
        if (p == 800) chk("big_blank_count", 32'(bblank), 32'd640);
    endtask

    initial begin
        // Reset applied before the first clock edge must act immediately.
        #1 reset = 1'b1;
        #1;
        chk("rst_x", 32'(bus.x), 32'd0);
        chk("rst_y", 32'(bus.y), 32'd0);
        chk("rst_visible", 32'(bus.visible), 32'd1);
        chk("rst_frame_tick", 32'(bus.frame_tick), 32'd0);
        chk("rst_hsync", 32'(bus.vga_hsync), 32'd1);
        chk("rst_vsync", 32'(bus.vga_vsync), 32'd1);
        chk("rst_blank_n", 32'(bus.vga_blank_n), 32'd0);
        chk("rst_r", 32'(bus.vga_r), 32'd0);
        chk("rst_big_hsync", 32'(bbus.vga_hsync), 32'd1);
        chk("rst_big_blank_n", 32'(bbus.vga_blank_n), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_hold_x", 32'(bus.x), 32'd0);
        chk("rst_hold_blank_n", 32'(bus.vga_blank_n), 32'd0);
        #2 reset = 1'b0;

        // Two full frames plus a little, constant-white renderer.
        while (cyc < 830) begin
            step();
            check_small(cyc);
            if (cyc <= 810) check_big(cyc);
        end
        chk("tick_count", 32'(ticks), 32'd2);

        // Coordinate ramp renderer for a further frame.
        ramp = 1'b1;
        while (cyc < 1240) begin
            step();
            check_small(cyc);
        end

        // Walk to (12,5) and hit reset between clock edges.
        while (((cyc % FT) != 132) && (cyc < 2000)) begin
            step();
            check_small(cyc);
        end
        chk("pre_reset_x", 32'(bus.x), 32'd12);
        chk("pre_reset_y", 32'(bus.y), 32'd5);
        #2 reset = 1'b1;
        #1;
        chk("async_x", 32'(bus.x), 32'd0);
        chk("async_y", 32'(bus.y), 32'd0);
        chk("async_hsync", 32'(bus.vga_hsync), 32'd1);
        chk("async_vsync", 32'(bus.vga_vsync), 32'd1);
        chk("async_blank_n", 32'(bus.vga_blank_n), 32'd0);
        chk("async_r", 32'(bus.vga_r), 32'd0);
        chk("async_g", 32'(bus.vga_g), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("async_hold_x", 32'(bus.x), 32'd0);
        #2 reset = 1'b0;

        n = 0;
        found = 1'b0;
        while ((n < 1000) && !found) begin
            @(posedge clk);
            #1;
            n++;
            if (bus.frame_tick === 1'b1) found = 1'b1;
        end
        chk("tick_after_reset", 32'(n), 32'd240);
        chk("tick_after_reset_x", 32'(bus.x), 32'd0);
        chk("tick_after_reset_y", 32'(bus.y), 32'd10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/vga_timing_out.md
Name: vga_timing_out

Overview:
- Timing-generator and output end of the VGA pixel interface. Produces the `x`, `y` and `visible` coordinates consumed by the pixel renderers.
- Takes back the renderer's combinational `r`/`g`/`b` and registers them. Emits board-level VGA pins (sync, blank, colour), all aligned to one pipeline stage.
- Also provides a once-per-frame tick that game logic uses to update object positions.
- Sits between the renderer/game modules and the DAC pins at the top level.

Parameters:
- `H_VISIBLE`, 640, active pixels per line
- `H_FRONT`, 16, horizontal front porch (clocks)
- `H_SYNC`, 96, hsync pulse width (clocks)
- `H_BACK`, 48, horizontal back porch (clocks)
- `V_VISIBLE`, 480, active lines per frame
- `V_FRONT`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vsync pulse width (lines)
- `V_BACK`, 33, vertical back porch (lines)
- `HSYNC_POL`, 0, active level of hsync (0 = active-low)
- `VSYNC_POL`, 0, active level of vsync (0 = active-low)

Ports:
- `clk`  in  1  pixel clock, 25 MHz
- `reset`  in  1  asynchronous active-high reset
- `r_in`, `g_in`, `b_in`  in  8 each  pixel colour from renderer for current (`x`, `y`)
- `x`  out  10  current horizontal count (0..H_TOTAL-1)
- `y`  out  10  current vertical count (0..V_TOTAL-1)
- `visible`  out  1  high when `x` < `H_VISIBLE` and `y` < `V_VISIBLE`
- `frame_tick`  out  1  one-cycle pulse per frame at start of vertical blanking
- `vga_hsync`  out  1  horizontal sync pin
- `vga_vsync`  out  1  vertical sync pin
- `vga_blank_n`  out  1  DAC blank, high during active video
- `vga_sync_n`  out  1  DAC sync-on-green, constant 0
- `vga_r`, `vga_g`, `vga_b`  out  8 each  registered colour to DAC

Behaviour:
- Interface decision: one clock (`clk`); reset `reset` is asynchronous and active-high.
- Totals:
  - H_TOTAL = sum of the H_* parameters (800).
  - V_TOTAL = sum of the V_* parameters (525).
  - Both must be ≤ 1024. This is an elaboration-time check; violation is a fatal error.
- Counters:
  - `hcount` and `vcount` are 10-bit registers driven directly onto `x` and `y`.
  - `hcount` increments every clk and wraps from H_TOTAL-1 to 0.
  - `vcount` increments only on the cycle `hcount` wraps, and wraps from V_TOTAL-1 to 0 on that same edge.
- Combinational outputs (same cycle as `x`/`y`, no latency):
  - `visible` = (hcount < H_VISIBLE) && (vcount < V_VISIBLE).
  - `frame_tick` = (hcount == 0) && (vcount == V_VISIBLE). Exactly one cycle per frame; period H_TOTAL*V_TOTAL = 420000 clks.
- Output stage (registered, latency exactly 1 clk from counter value to pin):
  - hsync region = hcount in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC-1] = [656, 751].
  - `vga_hsync` <= HSYNC_POL inside the hsync region, else ~HSYNC_POL.
  - vsync region = vcount in [V_VISIBLE+V_FRONT, V_VISIBLE+V_FRONT+V_SYNC-1] = [490, 491], evaluated over whole lines.
  - `vga_vsync` <= VSYNC_POL inside the vsync region, else ~VSYNC_POL.
  - `vga_blank_n` <= `visible`.
  - `vga_r`/`vga_g`/`vga_b` <= `visible` ? `r_in`/`g_in`/`b_in` : 0. Colour outside the active area is forced to zero whatever the renderer drives.
  - `vga_sync_n` is constant 0, not registered.
- Renderer contract: the renderer must produce colour combinationally from `x`/`y`/`visible` in the same cycle. A renderer with internal latency is not supported.
- Reset (asynchronous, takes effect immediately, including mid-frame):
  - `hcount` = `vcount` = 0, so `x` = `y` = 0, `visible` = 1, `frame_tick` = 0.
  - `vga_hsync` = ~HSYNC_POL and `vga_vsync` = ~VSYNC_POL (inactive).
  - `vga_blank_n` = 0 and colour = 0.
  - While reset is held, counters stay at 0.
  - First rising edge after release: counters advance to `hcount` = 1, and the output stage registers the (0,0) values.
- Boundaries:
  - Both counters wrapping on the same edge ((799,524) → (0,0)) is a single event; no frame_tick on that edge.
  - Counters never exceed H_TOTAL-1 / V_TOTAL-1.

Test Plan:
- Reset, then run 1 line. Required: `vga_hsync` low for exactly 96 consecutive clks, first low clk being the edge after `x` == 656. `vga_blank_n` high exactly 640 clks per line. `x` returns 0 after 800 clks.
- Hold `r_in`/`g_in`/`b_in` = FF continuously. Required: `vga_r`/`vga_g`/`vga_b` = FF only while `vga_blank_n` = 1, and 00 during all 160 blank clks of each line and all blank lines 480..524.
- Run 2 full frames. Required: `vga_vsync` low for exactly 1600 consecutive clks, starting at the edge after (`x`,`y`) = (0,490). `frame_tick` pulses once per frame, at (0,480), with pulses 420000 clks apart.
- Drive `r_in` = `x`[7:0], `g_in` = `y`[7:0]. Required: at every active clk `vga_r`/`vga_g` equal the previous cycle's `x`[7:0]/`y`[7:0] (1-clk latency).
- Assert `reset` asynchronously at (`x`,`y`) = (300,200), between clk edges, for 3 clks. Required: outputs reach reset values immediately (inactive syncs, `vga_blank_n` = 0, `x` = `y` = 0), without waiting for a clk edge. After release counting restarts; `frame_tick` next occurs 480*800 = 384000 clks after release.
- Run through (799,524). Required: next clk `x` = `y` = 0, no `frame_tick`, no glitch on sync pins.
